j_fifo: RTL and testbench

- Single-clock synchronous FIFO: byte-wide by default, 8 entries deep by default.
- Write port is qualified by wn; read port is qualified by rn.
- Read data is registered and appears on DATAOUT after the clock edge that performs the read.
- full and empty status flags are provided for use by upstream and downstream logic.

---
 rtl/j_fifo.sv | 98 +++++++++
 tb/tb_j_fifo.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/j_fifo.sv
// ---------------------------------------------------------------------------
// j_fifo : single-clock synchronous FIFO with registered read data.
//
// Ports
//   clock    in   1      rising-edge clock for all state
//   reset    in   1      synchronous reset, active-low (0 = reset)
//   wn       in   1      write enable, active-high
//   rn       in   1      read enable, active-high
//   DATAIN   in   WIDTH  write data, captured when a write is accepted
//   DATAOUT  out  WIDTH  registered read data, updated on an accepted read
//   full     out  1      FIFO holds DEPTH entries
//   empty    out  1      FIFO holds no entries
//
// Writes while full and reads while empty are ignored.
// An empty FIFO never bypasses write data to DATAOUT.
// ---------------------------------------------------------------------------
module j_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wn,
    input  logic             rn,
    input  logic [WIDTH-1:0] DATAIN,
    output logic [WIDTH-1:0] DATAOUT,
    output logic             full,
    output logic             empty
);

    localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wp_q,   wp_d;
    logic [AW-1:0]    rp_q,   rp_d;
    logic [AW:0]      cnt_q,  cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;

    logic do_wr;
    logic do_rd;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CNT_FULL);
    assign DATAOUT = dout_q;

    // Acceptance is gated by the flags of the current occupancy, so a
    // simultaneous request on an empty FIFO only writes, and on a full
    // FIFO only reads.
    assign do_wr = wn & ~full;
    assign do_rd = rn & ~empty;

    always_comb begin
        wp_d   = wp_q;
        rp_d   = rp_q;
        cnt_d  = cnt_q;
        dout_d = dout_q;

        if (do_wr) begin
            wp_d = wp_q + 1'b1;
        end

        if (do_rd) begin
            rp_d   = rp_q + 1'b1;
            dout_d = mem_q[rp_q];
        end

        if (do_wr && !do_rd) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_rd && !do_wr) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wp_q   <= '0;
            rp_q   <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
        end else begin
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    // Storage is not reset; reset only returns the pointers, so stale
    // contents are unreachable until overwritten.
    always_ff @(posedge clock) begin
        if (reset && do_wr) begin
            mem_q[wp_q] <= DATAIN;
        end
    end

endmodule

// File: tb/tb_j_fifo.sv
// ---------------------------------------------------------------------------
// tb_j_fifo : self-checking bench for j_fifo (WIDTH=8, DEPTH=8).
// A queue holds the data expected to come out of the FIFO: values are
// pushed when a write is accepted and popped when an accepted read makes
// them appear on DATAOUT.
// ---------------------------------------------------------------------------
module tb_j_fifo;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 8;

    logic             clock;
    logic             reset;
    logic             wn;
    logic             rn;
    logic [WIDTH-1:0] DATAIN;
    logic [WIDTH-1:0] DATAOUT;
    logic             full;
    logic             empty;

    int unsigned n_tests;
    int unsigned n_fail;

    logic [WIDTH-1:0] sb_q [$];
    logic [WIDTH-1:0] last_out;

    j_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .wn      (wn),
        .rn      (rn),
        .DATAIN  (DATAIN),
        .DATAOUT (DATAOUT),
        .full    (full),
        .empty   (empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_dout"},  32'(DATAOUT), 32'(last_out));
        check({tag, "_empty"}, 32'(empty),   32'(sb_q.size() == 0));
        check({tag, "_full"},  32'(full),    32'(sb_q.size() == DEPTH));
    endtask

    // One clock with the given requests; the queue decides what is accepted.
    task automatic cycle(input logic w, input logic r, input logic [WIDTH-1:0] d, input string tag);
        bit acc_wr;
        bit acc_rd;
        wn     = w;
        rn     = r;
        DATAIN = d;
        acc_wr = w && (sb_q.size() < DEPTH);
        acc_rd = r && (sb_q.size() > 0);
        if (acc_rd) last_out = sb_q.pop_front();
        if (acc_wr) sb_q.push_back(d);
        @(posedge clock);
        #1;
        check_state(tag);
    endtask

    // Reset with both requests asserted to show reset wins.
    task automatic do_reset(input string tag);
        reset  = 1'b0;
        wn     = 1'b1;
        rn     = 1'b1;
        DATAIN = 8'hA5;
        sb_q.delete();
        last_out = '0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        wn    = 1'b0;
        rn    = 1'b0;
        check_state(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] order_vals [7];
        n_tests  = 0;
        n_fail   = 0;
        last_out = '0;
        reset    = 1'b0;
        wn       = 1'b0;
        rn       = 1'b0;
        DATAIN   = '0;

        do_reset("reset");

        // Order check: 7 writes, then 8 reads (the last one underflows).
        order_vals = '{8'd100, 8'd150, 8'd200, 8'd40, 8'd70, 8'd65, 8'd15};
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, order_vals[i], "order_wr");
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'd0, "order_rd");
        check("order_hold15", 32'(DATAOUT), 32'd15);

        // Fill, overflow attempt, drain, underflow attempt.
        for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 8'(i), "fill_wr");
        check("full_after8", 32'(full), 32'd1);
        cycle(1'b1, 1'b0, 8'd99, "overflow_wr");
        cycle(1'b1, 1'b1, 8'd99, "full_both");
        check("full_drop_dout", 32'(DATAOUT), 32'd1);
        check("full_after_rd", 32'(full), 32'd0);
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 8'd0, "drain_rd");
        check("drain_last", 32'(DATAOUT), 32'd8);
        cycle(1'b0, 1'b1, 8'd0, "underflow_rd");

        // Wrap-around: 5 in/out moves pointers past the midpoint, then 8/8.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'd30 + 8'(i)), "wrap_wr5");
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'd0, "wrap_rd5");
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'(8'd50 + 8'(i)), "wrap_wr8");
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'd0, "wrap_rd8");

        // Simultaneous on empty: write only, no bypass.
        cycle(1'b1, 1'b1, 8'd77, "empty_both");
        cycle(1'b0, 1'b1, 8'd0,  "empty_both_rd");

        // Simultaneous with 3 stored entries.
        cycle(1'b1, 1'b0, 8'd10, "sim_wr");
        cycle(1'b1, 1'b0, 8'd20, "sim_wr");
        cycle(1'b1, 1'b0, 8'd30, "sim_wr");
        cycle(1'b1, 1'b1, 8'd40, "sim_both");
        check("sim_dout10", 32'(DATAOUT), 32'd10);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'd0, "sim_rd");
        check("sim_last40", 32'(DATAOUT), 32'd40);
        check("sim_empty", 32'(empty), 32'd1);

        // Mid-operation reset discards data; following read is ignored.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'(8'd200 + 8'(i)), "mid_wr");
        do_reset("mid_reset");
        cycle(1'b0, 1'b1, 8'd0, "post_reset_rd");
        check("post_reset_dout0", 32'(DATAOUT), 32'd0);

        // Random traffic, including idle cycles.
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)), "rand");
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 8'hEE, "idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
